lsu_periph_bridge: RTL and testbench

LSU_PERIPH_BRIDGE -- requirements
Module: lsu_periph_bridge

---
 rtl/lsu_bridge_pkg.sv | 19 +
 rtl/lsu_periph_bridge_if.sv | 34 +++
 rtl/periph_timeout_ctr.sv | 26 ++
 rtl/lsu_periph_bridge.sv | 120 ++++++++++++
 tb/tb_lsu_periph_bridge.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bridge_pkg.sv
// Shared types and constants for the LSU peripheral bridge.
// Holds the FSM state enum, the sentinel words and the region decode.
package lsu_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] IDLE_WORD    = 32'hdeadbeef;
    localparam logic [31:0] TIMEOUT_WORD = 32'hbabecafe;

    // Any non-zero byte in addr[15:8] selects the peripheral region.
    function automatic logic region_is_periph(input logic [7:0] region);
        return region != 8'h00;
    endfunction

endpackage

// File: rtl/lsu_periph_bridge_if.sv
// LSU-side and peripheral-side signal bundle for lsu_periph_bridge.
// master = the bridge itself, slave = the LSU/peripheral environment.
interface lsu_periph_bridge_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [3:0]  strb;
    logic        stall;
    logic        dmem_wr;
    logic [31:0] to_lsu;
    logic        p_req;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic        p_ack;
    logic [31:0] p_rdata;
    logic        p_err;

    modport master (
        input  addr, wdata, rd_en, wr_en, strb, p_ack, p_rdata,
        output stall, dmem_wr, to_lsu, p_req, p_we,
        output p_addr, p_wdata, p_strb, p_err
    );

    modport slave (
        output addr, wdata, rd_en, wr_en, strb, p_ack, p_rdata,
        input  stall, dmem_wr, to_lsu, p_req, p_we,
        input  p_addr, p_wdata, p_strb, p_err
    );

endinterface

// File: rtl/periph_timeout_ctr.sv
// Wait counter for a pending peripheral request.
// expired is asserted while enabled with the count at LIMIT-1.
module periph_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] r_cnt;

    // Count REQ cycles; restarts from zero whenever the request ends.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expired = enable && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/lsu_periph_bridge.sv
// Bridge from the LSU to a simple req/ack peripheral bus.
// Optional timeout abort is built only with PERIPH_TIMEOUT_EN defined.
module lsu_periph_bridge
    import lsu_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_periph_bridge_if.master  bus
);

    state_t      r_state;
    logic        r_p_req;
    logic        r_p_we;
    logic [31:0] r_p_addr;
    logic [31:0] r_p_wdata;
    logic [3:0]  r_p_strb;
    logic [31:0] r_to_lsu;

    logic        w_periph;
    logic        w_access;
    logic        w_timeout;

    assign w_periph = region_is_periph(bus.addr[15:8]);
    assign w_access = w_periph && (bus.rd_en || bus.wr_en);

`ifdef PERIPH_TIMEOUT_EN
    logic w_in_req;
    logic w_expired;
    logic r_p_err;

    assign w_in_req = (r_state == ST_REQ);

    periph_timeout_ctr #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_req),
        .enable  (w_in_req),
        .expired (w_expired)
    );

    // An ack in the expiry cycle takes priority over the abort.
    assign w_timeout = w_expired && !bus.p_ack;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_err <= 1'b0;
        end else if (w_timeout) begin
            r_p_err <= 1'b1;
        end
    end

    assign bus.p_err = r_p_err;
`else
    assign w_timeout = 1'b0;
    assign bus.p_err = 1'b0;
`endif

    // Request FSM: latch access in IDLE, hold bus in REQ, one result cycle in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_p_req   <= 1'b0;
            r_p_we    <= 1'b0;
            r_p_addr  <= '0;
            r_p_wdata <= '0;
            r_p_strb  <= '0;
            r_to_lsu  <= IDLE_WORD;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_p_we    <= bus.wr_en;
                        r_p_addr  <= bus.addr;
                        r_p_wdata <= bus.wdata;
                        r_p_strb  <= bus.strb;
                        r_p_req   <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.p_ack) begin
                        if (!r_p_we) begin
                            r_to_lsu <= bus.p_rdata;
                        end
                        r_p_req <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_to_lsu <= TIMEOUT_WORD;
                        r_p_req  <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_to_lsu <= IDLE_WORD;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_p_req <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stall   = ((r_state == ST_IDLE) && w_access)
                       || (r_state == ST_REQ);
    assign bus.dmem_wr = bus.wr_en && !w_periph;
    assign bus.to_lsu  = r_to_lsu;
    assign bus.p_req   = r_p_req;
    assign bus.p_we    = r_p_we;
    assign bus.p_addr  = r_p_addr;
    assign bus.p_wdata = r_p_wdata;
    assign bus.p_strb  = r_p_strb;

endmodule

// File: tb/tb_lsu_periph_bridge.sv
// Self-checking bench for lsu_periph_bridge (directed plus random accesses).
// Expected results come from a transaction-level model of the bridge rules.
module tb_lsu_periph_bridge;
    import lsu_bridge_pkg::*;

    localparam int TO = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic exp_err;

    lsu_periph_bridge_if bus ();

    lsu_periph_bridge #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.strb    = '0;
        bus.p_ack   = 1'b0;
        bus.p_rdata = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, "_p_req"}, 32'(bus.p_req), 32'd0);
        chk({tag, "_p_we"}, 32'(bus.p_we), 32'd0);
        chk({tag, "_p_addr"}, bus.p_addr, 32'd0);
        chk({tag, "_p_wdata"}, bus.p_wdata, 32'd0);
        chk({tag, "_p_strb"}, 32'(bus.p_strb), 32'd0);
        chk({tag, "_to_lsu"}, bus.to_lsu, IDLE_WORD);
        chk({tag, "_p_err"}, 32'(bus.p_err), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        check_reset("reset");
    endtask

    task automatic dmem_access(input logic [31:0] a, input logic wr);
        @(posedge clk); #1;
        bus.addr  = a;
        bus.wdata = $urandom;
        bus.strb  = 4'hf;
        bus.rd_en = !wr;
        bus.wr_en = wr;
        bus.p_ack = 1'b0;
        @(negedge clk);
        chk("dmem_wr", 32'(bus.dmem_wr), 32'(wr));
        chk("dmem_stall", 32'(bus.stall), 32'd0);
        chk("dmem_p_req", 32'(bus.p_req), 32'd0);
    endtask

    // ack_n: REQ cycle carrying p_ack, 0 = never acked.
    // chain: present a new read at nxt during the DONE cycle.
    task automatic periph_txn(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic rd,
                              input logic wr, input int ack_n,
                              input logic [31:0] rdat, input bit chain,
                              input logic [31:0] nxt);
        int          n;
        int          stalls;
        bit          tmo;
        logic [31:0] exp_lsu;
        n   = ack_n;
        tmo = 1'b0;
`ifdef PERIPH_TIMEOUT_EN
        if (ack_n == 0 || ack_n > TO) begin
            n   = TO;
            tmo = 1'b1;
        end
`endif
        if (tmo) exp_lsu = TIMEOUT_WORD;
        else if (wr) exp_lsu = IDLE_WORD;
        else exp_lsu = rdat;
        stalls = 0;

        @(posedge clk); #1;
        bus.addr  = a;
        bus.wdata = wd;
        bus.strb  = st;
        bus.rd_en = rd;
        bus.wr_en = wr;
        bus.p_ack = 1'b0;
        @(negedge clk);
        chk("idle_to_lsu", bus.to_lsu, IDLE_WORD);
        chk("idle_dmem_wr", 32'(bus.dmem_wr), 32'd0);
        chk("idle_p_req", 32'(bus.p_req), 32'd0);
        if (bus.stall) stalls++;

        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                bus.rd_en = 1'b0;
                bus.wr_en = 1'b0;
                bus.addr  = $urandom;
                bus.wdata = $urandom;
                bus.strb  = 4'($urandom);
            end
            bus.p_ack   = (k == ack_n);
            bus.p_rdata = (k == ack_n) ? rdat : 32'($urandom);
            @(negedge clk);
            chk("req_p_req", 32'(bus.p_req), 32'd1);
            chk("req_p_we", 32'(bus.p_we), 32'(wr));
            chk("req_p_addr", bus.p_addr, a);
            chk("req_p_wdata", bus.p_wdata, wd);
            chk("req_p_strb", 32'(bus.p_strb), 32'(st));
            chk("req_dmem_wr", 32'(bus.dmem_wr), 32'd0);
            if (bus.stall) stalls++;
        end
        if (tmo) exp_err = 1'b1;

        @(posedge clk); #1;
        bus.p_ack   = 1'b1;
        bus.p_rdata = $urandom;
        if (chain) begin
            bus.addr  = nxt;
            bus.rd_en = 1'b1;
            bus.wr_en = 1'b0;
        end
        @(negedge clk);
        chk("done_stall", 32'(bus.stall), 32'd0);
        chk("done_p_req", 32'(bus.p_req), 32'd0);
        chk("done_to_lsu", bus.to_lsu, exp_lsu);
        chk("done_p_err", 32'(bus.p_err), 32'(exp_err));
        chk("stall_cycles", 32'(stalls), 32'(n + 1));

        if (!chain) begin
            @(posedge clk); #1;
            bus.p_ack = 1'b0;
            @(negedge clk);
            chk("after_to_lsu", bus.to_lsu, IDLE_WORD);
            chk("after_stall", 32'(bus.stall), 32'd0);
            chk("after_p_req", 32'(bus.p_req), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          sel;
        int          an;
        checks   = 0;
        failures = 0;
        exp_err  = 1'b0;
        rst      = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("init");

        dmem_access(32'h0000_0040, 1'b1);
        dmem_access(32'h1234_00fc, 1'b0);

        periph_txn(32'h0000_0100, 32'h0, 4'hf, 1'b1, 1'b0, 3,
                   32'h1234_5678, 1'b0, 32'h0);
        periph_txn(32'h0000_8004, 32'hA5A5_A5A5, 4'b0011, 1'b0, 1'b1, 2,
                   32'h0, 1'b0, 32'h0);
        periph_txn(32'h0000_0200, 32'h5555_aaaa, 4'b1100, 1'b1, 1'b1, 1,
                   32'h0, 1'b0, 32'h0);

        periph_txn(32'h0000_0300, 32'h0, 4'hf, 1'b1, 1'b0, 2,
                   32'hcafe_0001, 1'b1, 32'h0000_0400);
        periph_txn(32'h0000_0400, 32'h0, 4'hf, 1'b1, 1'b0, 1,
                   32'hcafe_0002, 1'b0, 32'h0);

`ifdef PERIPH_TIMEOUT_EN
        do_reset();
        periph_txn(32'h0000_0500, 32'h0, 4'hf, 1'b1, 1'b0, 0,
                   32'h0, 1'b0, 32'h0);
        periph_txn(32'h0000_0600, 32'h0, 4'hf, 1'b1, 1'b0, 2,
                   32'h0bad_f00d, 1'b0, 32'h0);
        do_reset();
        periph_txn(32'h0000_0700, 32'h0, 4'hf, 1'b1, 1'b0, TO,
                   32'h7777_1234, 1'b0, 32'h0);
`endif

        @(posedge clk); #1;
        bus.addr  = 32'h0000_0800;
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        exp_err     = 1'b0;
        bus.p_ack   = 1'b1;
        bus.p_rdata = 32'h1111_2222;
        @(negedge clk);
        check_reset("midreq_rst");
        @(posedge clk); #1;
        bus.p_ack = 1'b0;
        @(negedge clk);
        check_reset("late_ack");

        for (int i = 0; i < 24; i++) begin
            r   = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 3) begin
                a = {r[31:16], 8'h00, r[7:0]};
                dmem_access(a, r[0]);
            end else begin
                a = {r[31:16], 8'($urandom_range(1, 255)), r[7:0]};
`ifdef PERIPH_TIMEOUT_EN
                an = $urandom_range(0, 6);
`else
                an = $urandom_range(1, 6);
`endif
                periph_txn(a, $urandom, 4'($urandom),
                           (sel != 1), (sel != 0), an,
                           $urandom, 1'b0, 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
